// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Binary requester index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set req bit searching ptr+1 .. ptr+8 (mod 8).
// Latency: purely combinational, zero cycles.
// Backpressure: none; any=0 when no requester is asserted.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Walk the offsets from farthest to nearest so the nearest set bit after ptr
  // is the last write and therefore wins; offset 8 wraps back to ptr itself.
  always_comb begin
    any = |req;
    idx = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[ptr + IDX_W'(k)]) begin
        idx = ptr + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/rr_arb_8.sv
// 8:1 round-robin arbiter with bounded grant tenure and a one-cycle bubble between owners.
// Latency: request sampled on an edge in IDLE yields registered gnt/sel/busy after that same edge.
// Backpressure: owner keeps the path while its req stays high, up to MAX_HOLD cycles (0 = unbounded).
module rr_arb_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  // Counter value on which a still-requesting owner is forced off the path.
  localparam bit               HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [IDX_W-1:0]   sel_q,   sel_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               tmo_q,   tmo_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state logic: arbitrate in IDLE, hold/release/time out in GRANT.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // sel keeps the previous owner here so the shared mux stays quiet.
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = idx_to_onehot(pick_idx);
          sel_d   = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      GRANT: begin
        // Other requesters are ignored until the owner lets go.
        if (!req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
        end else if (cnt_q != '1) begin
          // Saturate so an unbounded tenure never wraps the counter.
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = tmo_q;

endmodule
